// File: rtl/ro_puf_eval_if.sv
// Challenge, oscillator and result bundle for ro_puf_eval.
// Defining PUF_MARGIN_EN adds the per-bit unstable flags.
interface ro_puf_eval_if #(
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [SEL_W-1:0]     chal_a;
    logic [SEL_W-1:0]     chal_b;
    logic [WIN_W-1:0]     win_len;
    logic                 ro_a;
    logic                 ro_b;
    logic [SEL_W-1:0]     sel_a;
    logic [SEL_W-1:0]     sel_b;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [CNT_W-1:0]     cnt_a_last;
    logic [CNT_W-1:0]     cnt_b_last;
`ifdef PUF_MARGIN_EN
    logic [RESP_BITS-1:0] unstable;
`endif

    modport master (
        output start, chal_a, chal_b, win_len, ro_a, ro_b,
        input  sel_a, sel_b, busy, done, response, cnt_a_last, cnt_b_last
`ifdef PUF_MARGIN_EN
        , input unstable
`endif
    );

    modport slave (
        input  start, chal_a, chal_b, win_len, ro_a, ro_b,
        output sel_a, sel_b, busy, done, response, cnt_a_last, cnt_b_last
`ifdef PUF_MARGIN_EN
        , output unstable
`endif
    );
endinterface

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF response generator: per bit, select an oscillator pair,
// count edges over a window, compare. PUF_MARGIN_EN adds per-bit unstable flags.
module ro_puf_eval #(
    parameter int SEL_W      = 5,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 4
`ifdef PUF_MARGIN_EN
    , parameter int MARGIN   = 8
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    ro_puf_eval_if.slave  bus
);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

    state_t               state_q, state_d;
    logic                 busy, done;
    logic [SEL_W-1:0]     sel_a_q, sel_b_q;
    logic [WIN_W-1:0]     win_q, tmr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [RESP_BITS-1:0] resp_q;
    logic [CNT_W-1:0]     cnt_a_q, cnt_b_q, last_a_q, last_b_q;
    logic [2:0]           sync_a, sync_b;
    logic                 rise_a, rise_b;
`ifdef PUF_MARGIN_EN
    logic [RESP_BITS-1:0] unst_q;
    logic [CNT_W-1:0]     diff;
    assign diff = (cnt_a_q > cnt_b_q) ? cnt_a_q - cnt_b_q : cnt_b_q - cnt_a_q;
    assign bus.unstable = unst_q;
`endif

    // sync[1] is the second synchroniser stage, sync[2] the edge-detect stage
    assign rise_a = sync_a[1] & ~sync_a[2];
    assign rise_b = sync_b[1] & ~sync_b[2];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], bus.ro_a};
            sync_b <= {sync_b[1:0], bus.ro_b};
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE: begin
                busy = 1'b1;
                if (tmr_q == WIN_W'(SETTLE_CYC - 1)) state_d = MEASURE;
            end
            MEASURE: begin
                busy = 1'b1;
                if (tmr_q == win_q - 1'b1) state_d = COMPARE;
            end
            COMPARE: begin
                busy    = 1'b1;
                state_d = (idx_q == IDX_W'(RESP_BITS - 1)) ? DONE : SETTLE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            win_q    <= '0;
            tmr_q    <= '0;
            idx_q    <= '0;
            resp_q   <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            last_a_q <= '0;
            last_b_q <= '0;
`ifdef PUF_MARGIN_EN
            unst_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    sel_a_q <= bus.chal_a;
                    sel_b_q <= bus.chal_b;
                    win_q   <= (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
                    tmr_q   <= '0;
                    idx_q   <= '0;
                    resp_q  <= '0;
`ifdef PUF_MARGIN_EN
                    unst_q  <= '0;
`endif
                end
                SETTLE: begin
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    tmr_q   <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
                end
                MEASURE: begin
                    tmr_q <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
                    if (rise_a && cnt_a_q != '1) cnt_a_q <= cnt_a_q + 1'b1;
                    if (rise_b && cnt_b_q != '1) cnt_b_q <= cnt_b_q + 1'b1;
                end
                COMPARE: begin
                    resp_q[idx_q] <= (cnt_a_q > cnt_b_q);
`ifdef PUF_MARGIN_EN
                    unst_q[idx_q] <= (diff < CNT_W'(MARGIN));
`endif
                    last_a_q <= cnt_a_q;
                    last_b_q <= cnt_b_q;
                    // sel tracks chal + i by incrementing in step with i
                    if (state_d == SETTLE) begin
                        idx_q   <= idx_q + 1'b1;
                        sel_a_q <= sel_a_q + 1'b1;
                        sel_b_q <= sel_b_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sel_a      = sel_a_q;
    assign bus.sel_b      = sel_b_q;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.response   = resp_q;
    assign bus.cnt_a_last = last_a_q;
    assign bus.cnt_b_last = last_b_q;
endmodule

// File: tb/tb_ro_puf_eval.sv
// Scoreboard bench for ro_puf_eval: directed evaluations on a default instance
// and a CNT_W=4 instance; a done monitor and a select monitor pop expectations.
module tb_ro_puf_eval;
    localparam int SEL_W = 5, CNT_W = 16, WIN_W = 16, RB = 8;
    localparam int CNT2_W = 4, RB2 = 2;

    typedef struct {
        logic [7:0]  resp;
        logic [15:0] ca;
        logic [15:0] cb;
        int          lat;
        logic [7:0]  unst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ro_puf_eval_if #(.SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .RESP_BITS(RB)) bus1 ();
    ro_puf_eval_if #(.SEL_W(SEL_W), .CNT_W(CNT2_W), .WIN_W(WIN_W), .RESP_BITS(RB2)) bus2 ();

    ro_puf_eval #(.SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .RESP_BITS(RB), .SETTLE_CYC(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    ro_puf_eval #(.SEL_W(SEL_W), .CNT_W(CNT2_W), .WIN_W(WIN_W), .RESP_BITS(RB2), .SETTLE_CYC(4))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int errors = 0, checks = 0;
    int cyc = 0, ph = 0, pa = 0, pb = 0;
    int start1_cyc = 0, start2_cyc = 0, done1_cnt = 0;
    exp_t q1[$], q2[$];
    logic [9:0] sq[$];
    logic busy_prev = 1'b0;
    logic [4:0] sela_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator model: a one-cycle high pulse every p cycles, p=2 toggles each clk
    always @(negedge clk) begin
        ph++;
        bus1.ro_a = (pa != 0) && (ph % pa == 0);
        bus1.ro_b = (pb != 0) && (ph % pb == 0);
        bus2.ro_a = bus1.ro_a;
        bus2.ro_b = bus1.ro_b;
    end

    always @(negedge clk) if (bus1.done) begin
        exp_t e;
        done1_cnt++;
        if (q1.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
        else begin
            e = q1.pop_front();
            check("resp1", 32'(bus1.response), 32'(e.resp));
            check("cnt_a1", 32'(bus1.cnt_a_last), 32'(e.ca));
            check("cnt_b1", 32'(bus1.cnt_b_last), 32'(e.cb));
            check("lat1", 32'(cyc - start1_cyc + 1), 32'(e.lat));
`ifdef PUF_MARGIN_EN
            check("unst1", 32'(bus1.unstable), 32'(e.unst));
`endif
        end
    end

    always @(negedge clk) if (bus2.done) begin
        exp_t e;
        if (q2.size() == 0) check("done2_unexpected", 32'd1, 32'd0);
        else begin
            e = q2.pop_front();
            check("resp2", 32'(bus2.response), 32'(e.resp));
            check("cnt_a2", 32'(bus2.cnt_a_last), 32'(e.ca));
            check("cnt_b2", 32'(bus2.cnt_b_last), 32'(e.cb));
            check("lat2", 32'(cyc - start2_cyc + 1), 32'(e.lat));
`ifdef PUF_MARGIN_EN
            check("unst2", 32'(bus2.unstable), 32'(e.unst));
`endif
        end
    end

    // A new select pair appears when busy rises or sel_a steps
    always @(negedge clk) begin
        if (bus1.busy && (!busy_prev || bus1.sel_a != sela_prev)) begin
            logic [9:0] s;
            if (sq.size() == 0) check("sel_unexpected", 32'd1, 32'd0);
            else begin
                s = sq.pop_front();
                check("sel_a", 32'(bus1.sel_a), 32'(s[9:5]));
                check("sel_b", 32'(bus1.sel_b), 32'(s[4:0]));
            end
        end
        busy_prev = bus1.busy;
        sela_prev = bus1.sel_a;
    end

    task automatic start1(input logic [4:0] ca, input logic [4:0] cb, input logic [15:0] wl,
                          input int pa_n, input int pb_n, input bit push, input exp_t e);
        pa = pa_n;
        pb = pb_n;
        repeat (5) @(negedge clk);
        bus1.chal_a = ca;
        bus1.chal_b = cb;
        bus1.win_len = wl;
        bus1.start = 1'b1;
        start1_cyc = cyc;
        if (push) q1.push_back(e);
        for (int i = 0; i < RB; i++) begin
            logic [4:0] sa, sb;
            sa = ca + 5'(i);
            sb = cb + 5'(i);
            sq.push_back({sa, sb});
        end
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (which == 1 && q1.size() == 0 && !bus1.busy) begin ok = 1'b1; break; end
            if (which == 2 && q2.size() == 0 && !bus2.busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout", 32'(which), 32'd0);
    endtask

    initial begin
        exp_t e;
        int d0;
        bit seen;
        bus1.start = 1'b0; bus1.chal_a = '0; bus1.chal_b = '0; bus1.win_len = '0;
        bus2.start = 1'b0; bus2.chal_a = '0; bus2.chal_b = '0; bus2.win_len = '0;
        #1;
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_done", 32'(bus1.done), 32'd0);
        check("rst_resp", 32'(bus1.response), 32'd0);
        check("rst_sel", 32'({bus1.sel_a, bus1.sel_b}), 32'd0);
        check("rst_cnt", 32'({bus1.cnt_a_last, bus1.cnt_b_last}), 32'd0);
        check("rst_busy2", 32'(bus2.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        // A faster than B: 60/3=20 vs 60/5=12, latency 8*(4+60+1)+2
        e = '{resp: 8'hFF, ca: 16'd20, cb: 16'd12, lat: 522, unst: 8'h00};
        start1(5'd0, 5'd16, 16'd60, 3, 5, 1'b1, e);
        wait_idle(1, 700);

        // Shared source: every compare ties
        e = '{resp: 8'h00, ca: 16'd10, cb: 16'd10, lat: 362, unst: 8'hFF};
        start1(5'd5, 5'd9, 16'd40, 4, 4, 1'b1, e);
        wait_idle(1, 500);

        // Select wrap 30,31,0..5; 10/2=5 edges vs 0
        e = '{resp: 8'hFF, ca: 16'd5, cb: 16'd0, lat: 122, unst: 8'hFF};
        start1(5'd30, 5'd2, 16'd10, 2, 0, 1'b1, e);
        wait_idle(1, 300);

        // Saturation on the 4-bit instance: 50 edges clamp to 15
        pa = 2;
        pb = 0;
        repeat (5) @(negedge clk);
        bus2.chal_a = 5'd1; bus2.chal_b = 5'd7; bus2.win_len = 16'd100;
        bus2.start = 1'b1;
        start2_cyc = cyc;
        q2.push_back('{resp: 8'h03, ca: 16'd15, cb: 16'd0, lat: 212, unst: 8'h00});
        @(negedge clk);
        bus2.start = 1'b0;
        wait_idle(2, 400);

        // win_len=0 runs a one-cycle window; starts while busy and in DONE are ignored
        d0 = done1_cnt;
        e = '{resp: 8'h00, ca: 16'd0, cb: 16'd0, lat: 50, unst: 8'hFF};
        start1(5'd0, 5'd0, 16'd0, 0, 0, 1'b1, e);
        repeat (10) @(negedge clk);
        bus1.chal_a = 5'd17; bus1.win_len = 16'd3; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus1.done) begin seen = 1'b1; break; end
        end
        check("done_seen", 32'(seen), 32'd1);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (60) @(negedge clk);
        check("done_once", 32'(done1_cnt - d0), 32'd1);
        check("busy_after_done_start", 32'(bus1.busy), 32'd0);

        // Reset during bit 2 MEASURE aborts with no done pulse
        d0 = done1_cnt;
        start1(5'd3, 5'd20, 16'd60, 3, 5, 1'b0, e);
        repeat (145) @(negedge clk);
        check("mid_resp_pre", 32'(bus1.response), 32'h03);
        check("mid_busy_pre", 32'(bus1.busy), 32'd1);
        rst_n = 1'b1;
        #1;
        check("abort_busy", 32'(bus1.busy), 32'd0);
        check("abort_resp", 32'(bus1.response), 32'd0);
        check("abort_sel", 32'({bus1.sel_a, bus1.sel_b}), 32'd0);
        check("abort_cnt", 32'({bus1.cnt_a_last, bus1.cnt_b_last}), 32'd0);
        sq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (600) @(negedge clk);
        check("abort_no_done", 32'(done1_cnt - d0), 32'd0);
        check("abort_idle", 32'(bus1.busy), 32'd0);

        check("queues_empty", 32'(q1.size() + q2.size() + sq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ro_puf_eval.md
Name: ro_puf_eval

Overview:
Synchronous, parametrised response generator for the ring-oscillator PUF array. For each response bit it selects two oscillators through the external select mux and counts their rising edges over a programmable window in the clk domain. It then compares the two counts and shifts the comparison bit into a multi-bit response register. It replaces the single free-running counter/compare pair with a challenge-driven, multi-bit, saturating and windowed measurement.

Parameters:
SEL_W, 5, oscillator select width (2^SEL_W oscillators per bank)
CNT_W, 16, edge-counter width
WIN_W, 16, measurement-window length register width
RESP_BITS, 8, response bits generated per evaluation
SETTLE_CYC, 4, clk cycles of synchroniser flush after each select change

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-high (asserted = 1)
start  in  1  one-cycle request to begin an evaluation
chal_a  in  SEL_W  base index for oscillator bank A
chal_b  in  SEL_W  base index for oscillator bank B
win_len  in  WIN_W  measurement window in clk cycles
ro_a  in  1  selected oscillator A output, asynchronous to clk
ro_b  in  1  selected oscillator B output, asynchronous to clk
sel_a  out  SEL_W  select to bank-A mux
sel_b  out  SEL_W  select to bank-B mux
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse when response is complete
response  out  RESP_BITS  response register, bit 0 = first comparison
cnt_a_last  out  CNT_W  bank-A count of most recent bit
cnt_b_last  out  CNT_W  bank-B count of most recent bit

Behaviour:
- Reset (rst_n=1, async): state IDLE; sel_a, sel_b, response, cnt_*_last, bit index, window counter and edge counters = 0; busy = 0, done = 0.
- ro_a and ro_b each pass through a 2-FF synchroniser plus an edge-detect FF. A rising edge = sync_q1 & ~sync_q2.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE: on start=1, latch chal_a, chal_b and win_len (win_len=0 is treated as 1). Clear response and bit index i. Go to SETTLE. busy=1 from the next cycle.
- SETTLE: sel_a = chal_a + i and sel_b = chal_b + i (mod 2^SEL_W, wrap-around). Edge counters are held at 0 for SETTLE_CYC cycles, then go to MEASURE.
- MEASURE: lasts exactly win_len cycles. Each counter increments on a detected edge. Counters saturate at 2^CNT_W-1 and never wrap. Go to COMPARE.
- COMPARE (1 cycle): bit = (cnt_a > cnt_b); a tie gives 0. Write the bit to response[i]. Copy the counts to cnt_*_last. If i = RESP_BITS-1 go to DONE, else increment i and go to SETTLE.
- DONE (1 cycle): done=1, busy=0, then IDLE. response and cnt_*_last hold until the next start.
- start while busy: ignored. start in the DONE cycle: ignored.
- Latency per evaluation: 1 + RESP_BITS*(SETTLE_CYC + win_len + 1) + 1 cycles from the start cycle to the done pulse.
- Reset mid-evaluation: immediate abort to the reset values. No done pulse.
- Comparison is unsigned over CNT_W bits.

Optional Feature:
Macro PUF_MARGIN_EN. When defined, adds parameter MARGIN (default 8) and output unstable[RESP_BITS]. In COMPARE, unstable[i] = (|cnt_a - cnt_b| < MARGIN). unstable clears on start and on reset, and is valid with done. When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset with rst_n=1 during MEASURE: busy=0, response=0, sel_a=sel_b=0 immediately. No done pulse.
- ro_a period 3 clk, ro_b period 5 clk, win_len=60, RESP_BITS=8, chal_a=0, chal_b=16: response=8'hFF, cnt_a_last≈20, cnt_b_last≈12, done after 8*(4+60+1)+2 = 522 cycles.
- Both inputs from the same source, period 4 clk, win_len=40: every compare is a tie, response=8'h00; with PUF_MARGIN_EN, unstable=8'hFF.
- chal_a=30, RESP_BITS=8: sel_a sequence 30, 31, 0, 1, 2, 3, 4, 5 (wrap). Check sel values during each SETTLE.
- CNT_W=4, ro_a toggling every clk, win_len=100: cnt_a_last=15 (saturated, no wrap).
- win_len=0: window is 1 cycle. A second start pulse while busy: no restart, exactly one done pulse.
